// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding and the zero-register constant.
package hazard_ctrl_pkg;

    typedef enum logic {
        StRun,
        StMdWait
    } hc_state_e;

    localparam logic [4:0] ZeroReg = 5'd0;

endpackage

// File: rtl/hazard_cmp.sv
// Source/destination register comparator for load-use detection; also used by forwarding.
module hazard_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_rs,
    input  logic [4:0] src_rt,
    input  logic       src_uses_rt,
    input  logic       dst_valid,
    input  logic [4:0] dst_reg,
    output logic       hit
);

    // $zero is never a real dependency.
    assign hit = dst_valid && (dst_reg != ZeroReg) &&
                 ((dst_reg == src_rs) || (src_uses_rt && (dst_reg == src_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush control for PC, IF/ID and ID/EX: load-use stalls, redirect squash,
// and front-end stall while a mult/div occupies EX.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              id_branch_taken,
    input  logic              id_jump,
    input  logic              id_md,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              if_flush,
    output logic              id_ex_bubble,
    output logic              md_busy,
    output logic [PERF_W-1:0] perf_stalls
);

    localparam int unsigned     CntW    = $clog2(MD_LATENCY);
    localparam logic [CntW-1:0] CntLoad = CntW'(MD_LATENCY - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(1);

    hc_state_e         state_q, state_d;
    logic [CntW-1:0]   md_cnt_q, md_cnt_d;
    logic [PERF_W-1:0] perf_q;

    logic lu;
    logic redirect;
    logic pc_hold_c, if_id_hold_c, if_flush_c, bubble_c;

    hazard_cmp u_cmp (
        .src_rs      (id_rs),
        .src_rt      (id_rt),
        .src_uses_rt (id_uses_rt),
        .dst_valid   (ex_mem_read),
        .dst_reg     (ex_rt),
        .hit         (lu)
    );

    assign redirect = id_branch_taken | id_jump;

    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        pc_hold_c    = 1'b0;
        if_id_hold_c = 1'b0;
        if_flush_c   = 1'b0;
        bubble_c     = 1'b0;
        unique case (state_q)
            StRun: begin
                if (lu) begin
                    // Redirect/md wait: they are re-seen once the load has left EX.
                    pc_hold_c    = 1'b1;
                    if_id_hold_c = 1'b1;
                    bubble_c     = 1'b1;
                end else begin
                    if (redirect) begin
                        if_id_hold_c = 1'b1;
                        if_flush_c   = 1'b1;
                    end
                    if (id_md) begin
                        state_d  = StMdWait;
                        md_cnt_d = CntLoad;
                    end
                end
            end
            StMdWait: begin
                pc_hold_c    = 1'b1;
                if_id_hold_c = 1'b1;
                bubble_c     = 1'b1;
                md_cnt_d     = md_cnt_q - CntLast;
                if (md_cnt_q == CntLast) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d  = StRun;
                md_cnt_d = '0;
            end
        endcase
    end

    // Reset must silence the pipeline controls without waiting for a clock edge.
    assign pc_hold      = rst_n & pc_hold_c;
    assign if_id_hold   = rst_n & if_id_hold_c;
    assign if_flush     = rst_n & if_flush_c;
    assign id_ex_bubble = rst_n & bubble_c;
    assign md_busy      = (state_q == StMdWait);
    assign perf_stalls  = perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            md_cnt_q <= '0;
            perf_q   <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (pc_hold_c && (perf_q != {PERF_W{1'b1}})) begin
                perf_q <= perf_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed cases plus random traffic against a
// cycle-level reference model; a narrow-counter instance checks saturation.
module tb_hazard_ctrl;

    localparam int unsigned Lat = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_branch_taken, id_jump, id_md, ex_mem_read;
    logic        pc_hold, if_id_hold, if_flush, id_ex_bubble, md_busy;
    logic [31:0] perf_stalls;
    logic        s_pc_hold, s_if_id_hold, s_if_flush, s_id_ex_bubble, s_md_busy;
    logic [3:0]  s_perf_stalls;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(Lat), .PERF_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_branch_taken (id_branch_taken),
        .id_jump         (id_jump),
        .id_md           (id_md),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .pc_hold         (pc_hold),
        .if_id_hold      (if_id_hold),
        .if_flush        (if_flush),
        .id_ex_bubble    (id_ex_bubble),
        .md_busy         (md_busy),
        .perf_stalls     (perf_stalls)
    );

    hazard_ctrl #(.MD_LATENCY(Lat), .PERF_W(4)) dut_s (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_branch_taken (id_branch_taken),
        .id_jump         (id_jump),
        .id_md           (id_md),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .pc_hold         (s_pc_hold),
        .if_id_hold      (s_if_id_hold),
        .if_flush        (s_if_flush),
        .id_ex_bubble    (s_id_ex_bubble),
        .md_busy         (s_md_busy),
        .perf_stalls     (s_perf_stalls)
    );

    typedef struct packed {
        logic        ph;
        logic        ih;
        logic        fl;
        logic        bb;
        logic        busy;
        logic [31:0] perf;
        logic [3:0]  perf_s;
    } exp_t;

    exp_t   q[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     md_left = 0;
    longint stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs settle mid-cycle, compare on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            chk("pc_hold", 32'(pc_hold), 32'(e.ph));
            chk("if_id_hold", 32'(if_id_hold), 32'(e.ih));
            chk("if_flush", 32'(if_flush), 32'(e.fl));
            chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bb));
            chk("md_busy", 32'(md_busy), 32'(e.busy));
            chk("perf_stalls", perf_stalls, e.perf);
            chk("perf_stalls_w4", 32'(s_perf_stalls), 32'(e.perf_s));
            chk("w4_controls", 32'({s_pc_hold, s_if_id_hold, s_if_flush, s_id_ex_bubble, s_md_busy}),
                32'({e.ph, e.ih, e.fl, e.bb, e.busy}));
        end
    end

    // One cycle: apply inputs, predict the response from the rules, advance one clock.
    task automatic cyc(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic br, input logic jp, input logic md,
                       input logic mr, input logic [4:0] ert);
        exp_t e;
        logic lu;
        rst_n = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_branch_taken = br;
        id_jump = jp; id_md = md; ex_mem_read = mr; ex_rt = ert;
        e = '0;
        if (!rst) begin
            md_left   = 0;
            stall_cnt = 0;
        end else if (md_left > 0) begin
            e.ph = 1; e.ih = 1; e.bb = 1; e.busy = 1;
            md_left--;
        end else begin
            lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
            if (lu) begin
                e.ph = 1; e.ih = 1; e.bb = 1;
            end else begin
                if (br || jp) begin
                    e.ih = 1; e.fl = 1;
                end
                if (md) md_left = Lat - 1;
            end
        end
        e.perf   = 32'(stall_cnt);
        e.perf_s = (stall_cnt > 15) ? 4'd15 : 4'(stall_cnt);
        if (e.ph) stall_cnt++;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd8;
            2: return 5'd9;
            default: return 5'($urandom_range(1, 31));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_branch_taken = 1'b0;
        id_jump = 1'b0; id_md = 1'b0; ex_mem_read = 1'b0; ex_rt = '0;
        @(posedge clk);
        #1;
        // Reset with a live load-use pattern on the inputs: controls must still be 0.
        cyc(0, 8, 0, 0, 0, 0, 0, 1, 8);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use on rs, then $zero destination, then rt not used.
        cyc(1, 8, 0, 0, 0, 0, 0, 1, 8);
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 8, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 3, 8, 0, 0, 0, 0, 1, 8);
        cyc(1, 3, 8, 1, 0, 0, 0, 1, 8);
        // Branch alone, branch under load-use, jump.
        cyc(1, 3, 4, 1, 1, 0, 0, 0, 0);
        cyc(1, 8, 4, 1, 1, 0, 0, 1, 8);
        cyc(1, 3, 4, 1, 1, 0, 0, 0, 8);
        cyc(1, 3, 4, 1, 0, 1, 0, 0, 0);
        // mult/div issue then wait with noisy inputs.
        cyc(1, 3, 4, 1, 0, 0, 1, 0, 0);
        cyc(1, 8, 4, 1, 1, 0, 1, 1, 8);
        cyc(1, 3, 4, 1, 0, 1, 1, 0, 0);
        cyc(1, 3, 4, 1, 0, 0, 0, 0, 0);
        cyc(1, 3, 4, 1, 0, 0, 0, 0, 0);
        // mult/div together with a jump, then reset in the 2nd wait cycle.
        cyc(1, 3, 4, 1, 0, 1, 1, 0, 0);
        cyc(1, 3, 4, 1, 0, 0, 0, 0, 0);
        cyc(0, 3, 4, 1, 0, 0, 0, 0, 0);
        cyc(1, 3, 4, 1, 0, 0, 0, 0, 0);
        cyc(1, 3, 4, 1, 0, 0, 0, 0, 0);
        // 20 consecutive stalls from a clean counter: narrow counter pins at 15.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 8, 0, 0, 0, 0, 0, 1, 8);
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0);
        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0), pick_reg(), pick_reg(), 1'($urandom),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), 1'($urandom), pick_reg());
        end
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
